e_mdu: RTL

// Execute-stage multiply/divide unit; sits beside the E-stage ALU and consumes the same

---
 rtl/e_mdu.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div into HI/LO with a busy
// indication for hazard stalls, plus single-cycle moves to and from HI/LO.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic [31:0] MDURes,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   phi_q, phi_d, plo_q, plo_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d;

  logic [63:0] prod_s_s, prod_u_s;
  logic [31:0] a_mag_s, b_mag_s, qmag_s, rmag_s;
  logic [31:0] squot_s, srem_s, uquot_s, urem_s;
  logic        div_zero_s;

  // Signed divide runs on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with no overflow
  always_comb begin
    prod_s_s   = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u_s   = {32'd0, A} * {32'd0, B};
    a_mag_s    = A[31] ? (32'd0 - A) : A;
    b_mag_s    = B[31] ? (32'd0 - B) : B;
    div_zero_s = (B == 32'd0);
    if (div_zero_s) begin
      qmag_s  = 32'd0;
      rmag_s  = 32'd0;
      uquot_s = 32'd0;
      urem_s  = 32'd0;
    end else begin
      qmag_s  = a_mag_s / b_mag_s;
      rmag_s  = a_mag_s % b_mag_s;
      uquot_s = A / B;
      urem_s  = A % B;
    end
    squot_s = (A[31] ^ B[31]) ? (32'd0 - qmag_s) : qmag_s;
    srem_s  = A[31] ? (32'd0 - rmag_s) : rmag_s;
  end

  // Accept in IDLE, count down in RUN, commit pending HI/LO on the last busy cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT: begin
              {phi_d, plo_d} = prod_s_s;
              cnt_d = MULT_LOAD; busy_d = 1'b1; state_d = S_RUN;
            end
            OP_MULTU: begin
              {phi_d, plo_d} = prod_u_s;
              cnt_d = MULT_LOAD; busy_d = 1'b1; state_d = S_RUN;
            end
            OP_DIV: begin
              phi_d = div_zero_s ? hi_q : srem_s;
              plo_d = div_zero_s ? lo_q : squot_s;
              cnt_d = DIV_LOAD; busy_d = 1'b1; state_d = S_RUN;
            end
            OP_DIVU: begin
              phi_d = div_zero_s ? hi_q : urem_s;
              plo_d = div_zero_s ? lo_q : uquot_s;
              cnt_d = DIV_LOAD; busy_d = 1'b1; state_d = S_RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_ONE) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Read port for mfhi/mflo, not gated by busy
  always_comb begin
    MDURes = 32'd0;
    if (start && (MDUOp == OP_MFHI)) begin
      MDURes = hi_q;
    end else if (start && (MDUOp == OP_MFLO)) begin
      MDURes = lo_q;
    end else begin
      MDURes = 32'd0;
    end
  end

  // State, counter, pending and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
